// File: rtl/lab5_mcore_refill_net_if.sv
// Bundled val/rdy channels between the cache banks, the refill network and main memory.
// The slave modport is the network's view; the master modport is the banks-plus-memory side.
interface lab5_mcore_refill_net_if #(
   parameter int unsigned p_num_ports  = 4,
   parameter int unsigned p_req_nbits  = 175,
   parameter int unsigned p_resp_nbits = 145
);
   logic [p_num_ports-1:0][p_req_nbits-1:0]  cachereq_msg;
   logic [p_num_ports-1:0]                   cachereq_val;
   logic [p_num_ports-1:0]                   cachereq_rdy;
   logic [p_num_ports-1:0][p_resp_nbits-1:0] cacheresp_msg;
   logic [p_num_ports-1:0]                   cacheresp_val;
   logic [p_num_ports-1:0]                   cacheresp_rdy;
   logic [p_req_nbits-1:0]                   memreq_msg;
   logic                                     memreq_val;
   logic                                     memreq_rdy;
   logic [p_resp_nbits-1:0]                  memresp_msg;
   logic                                     memresp_val;
   logic                                     memresp_rdy;

   modport slave (
      input  cachereq_msg, cachereq_val, cacheresp_rdy, memreq_rdy, memresp_msg, memresp_val,
      output cachereq_rdy, cacheresp_msg, cacheresp_val, memreq_msg, memreq_val, memresp_rdy
   );

   modport master (
      output cachereq_msg, cachereq_val, cacheresp_rdy, memreq_rdy, memresp_msg, memresp_val,
      input  cachereq_rdy, cacheresp_msg, cacheresp_val, memreq_msg, memreq_val, memresp_rdy
   );
endinterface

// File: rtl/lab5_mcore_refill_net.sv
// Many-to-one refill network: per-bank request queues, round-robin merge onto one
// memory port, and in-order response routing through a source-ID FIFO.
module lab5_mcore_refill_net #(
   parameter int unsigned p_num_ports       = 4,
   parameter int unsigned p_queue_depth     = 2,
   parameter int unsigned p_max_outstanding = 4,
   parameter int unsigned p_req_nbits       = 175,
   parameter int unsigned p_resp_nbits      = 145
) (
   input  logic                   clk,
   input  logic                   reset,
   lab5_mcore_refill_net_if.slave bus
);
   localparam int unsigned N   = p_num_ports;
   localparam int unsigned D   = p_queue_depth;
   localparam int unsigned M   = p_max_outstanding;
   localparam int unsigned IW  = $clog2(N);
   localparam int unsigned QPW = (D > 1) ? $clog2(D) : 1;
   localparam int unsigned QCW = $clog2(D + 1);
   localparam int unsigned FPW = (M > 1) ? $clog2(M) : 1;
   localparam int unsigned FCW = $clog2(M + 1);

   typedef logic [p_req_nbits-1:0] req_t;

   req_t           qmem_q [N][D];
   logic [QPW-1:0] qwr_q  [N];
   logic [QPW-1:0] qwr_d  [N];
   logic [QPW-1:0] qrd_q  [N];
   logic [QPW-1:0] qrd_d  [N];
   logic [QCW-1:0] qcnt_q [N];
   logic [QCW-1:0] qcnt_d [N];
   logic [N-1:0]   q_push;
   logic [N-1:0]   q_pop;
   logic [N-1:0]   q_nempty;

   logic [IW-1:0]  id_mem_q [M];
   logic [FPW-1:0] id_wr_q, id_wr_d, id_rd_q, id_rd_d;
   logic [FCW-1:0] id_cnt_q, id_cnt_d;
   logic           id_empty, id_full, id_push, id_pop;

   logic [IW-1:0]  rr_q, rr_d, gnt_q, gnt_d;
   logic [IW-1:0]  arb_gnt, arb_idx, gnt, head;
   logic           arb_found;
   logic           lock_q, lock_d;
   logic           memreq_fire, memresp_fire;

   function automatic logic [QPW-1:0] q_inc(input logic [QPW-1:0] p);
      return (p == QPW'(D - 1)) ? '0 : p + QPW'(1);
   endfunction

   function automatic logic [FPW-1:0] f_inc(input logic [FPW-1:0] p);
      return (p == FPW'(M - 1)) ? '0 : p + FPW'(1);
   endfunction

   always_comb begin
      q_nempty = '0;
      for (int i = 0; i < int'(N); i++) q_nempty[i] = (qcnt_q[i] != '0);
   end

   // Round-robin search starting at the pointer over non-empty queues
   always_comb begin
      arb_gnt   = rr_q;
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int k = 0; k < int'(N); k++) begin
         arb_idx = IW'((32'(rr_q) + 32'(k)) % N);
         if (!arb_found && q_nempty[arb_idx]) begin
            arb_gnt   = arb_idx;
            arb_found = 1'b1;
         end
      end
   end

   // Once offered and stalled, the grant is frozen until the transfer fires
   assign gnt      = lock_q ? gnt_q : arb_gnt;
   assign id_empty = (id_cnt_q == '0);
   assign id_full  = (id_cnt_q == FCW'(M));
   assign head     = id_mem_q[id_rd_q];

   always_comb begin
      bus.cachereq_rdy = '0;
      for (int i = 0; i < int'(N); i++)
         bus.cachereq_rdy[i] = !reset && (qcnt_q[i] != QCW'(D));
      bus.memreq_val = !reset && (|q_nempty) && !id_full;
      bus.memreq_msg = qmem_q[gnt][qrd_q[gnt]];
      bus.cacheresp_val       = '0;
      bus.cacheresp_val[head] = !reset && !id_empty && bus.memresp_val;
      for (int i = 0; i < int'(N); i++) bus.cacheresp_msg[i] = bus.memresp_msg;
      bus.memresp_rdy = !reset && !id_empty && bus.cacheresp_rdy[head];
   end

   assign memreq_fire  = bus.memreq_val && bus.memreq_rdy;
   assign memresp_fire = bus.memresp_val && bus.memresp_rdy;
   assign id_push      = memreq_fire;
   assign id_pop       = memresp_fire;

   always_comb begin
      q_push = '0;
      q_pop  = '0;
      for (int i = 0; i < int'(N); i++) begin
         q_push[i] = bus.cachereq_val[i] && bus.cachereq_rdy[i];
         q_pop[i]  = memreq_fire && (gnt == IW'(i));
         qwr_d[i]  = q_push[i] ? q_inc(qwr_q[i]) : qwr_q[i];
         qrd_d[i]  = q_pop[i]  ? q_inc(qrd_q[i]) : qrd_q[i];
         qcnt_d[i] = qcnt_q[i] + QCW'(q_push[i]) - QCW'(q_pop[i]);
      end
   end

   always_comb begin
      id_wr_d  = id_push ? f_inc(id_wr_q) : id_wr_q;
      id_rd_d  = id_pop  ? f_inc(id_rd_q) : id_rd_q;
      id_cnt_d = id_cnt_q + FCW'(id_push) - FCW'(id_pop);
      rr_d     = rr_q;
      gnt_d    = gnt_q;
      lock_d   = lock_q;
      if (memreq_fire) begin
         rr_d   = (gnt == IW'(N - 1)) ? '0 : gnt + IW'(1);
         lock_d = 1'b0;
      end else if (bus.memreq_val) begin
         gnt_d  = gnt;
         lock_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(N); i++) begin
            qwr_q[i]  <= '0;
            qrd_q[i]  <= '0;
            qcnt_q[i] <= '0;
         end
         id_wr_q  <= '0;
         id_rd_q  <= '0;
         id_cnt_q <= '0;
         rr_q     <= '0;
         gnt_q    <= '0;
         lock_q   <= 1'b0;
      end else begin
         for (int i = 0; i < int'(N); i++) begin
            qwr_q[i]  <= qwr_d[i];
            qrd_q[i]  <= qrd_d[i];
            qcnt_q[i] <= qcnt_d[i];
         end
         id_wr_q  <= id_wr_d;
         id_rd_q  <= id_rd_d;
         id_cnt_q <= id_cnt_d;
         rr_q     <= rr_d;
         gnt_q    <= gnt_d;
         lock_q   <= lock_d;
      end
   end

   // Payload storage needs no reset; occupancy lives in the counters above
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(N); i++)
         if (q_push[i]) qmem_q[i][qwr_q[i]] <= bus.cachereq_msg[i];
      if (id_push) id_mem_q[id_wr_q] <= gnt;
   end
endmodule
